// File: rtl/program_loader.sv
// Program loader: buffers a program streamed in over a valid/ready handshake,
// then bursts it into a CPU's instruction-load port while that CPU is out of
// reset. After the burst, the CPU is held in reset for a few cycles and then
// released to run. A start pulse in RUN reloads the CPU.
module program_loader #(
    parameter int MAX_WORDS      = 32,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         Reset,
    input  logic                         start,
    input  logic                         in_valid,
    input  logic [31:0]                  in_data,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic                         LoadInstructions,
    output logic [31:0]                  Instruction,
    output logic                         cpu_reset,
    output logic                         done,
    output logic [$clog2(MAX_WORDS):0]   word_count,
    output logic                         trunc
);

    localparam int CW = $clog2(MAX_WORDS) + 1;
    localparam int AW = $clog2(MAX_WORDS);

    localparam logic [CW-1:0] FULL      = CW'(MAX_WORDS);
    localparam logic [CW-1:0] LAST_SLOT = CW'(MAX_WORDS - 1);
    localparam logic [3:0]    REL_LAST  = 4'(RELEASE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_BURST,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [3:0]    rel_cnt;
    logic [31:0]   buffer [MAX_WORDS];
    logic          transfer;

    // The write pointer doubles as the captured-word count.
    assign word_count = wr_ptr;
    assign in_ready   = (state == S_FILL) && (wr_ptr < FULL);
    assign transfer   = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk or negedge Reset) begin
        // NOTE: sequential state is always updated with non-blocking assignments
        // so every register samples the pre-edge values of its inputs.
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: defaulting state_next before the case keeps this block free of
        // inferred latches for any path that does not assign it.
        state_next = state;
        unique case (state)
            S_IDLE:    if (start) state_next = S_FILL;
            S_FILL:    if (transfer && (in_last || wr_ptr == LAST_SLOT)) state_next = S_BURST;
            S_BURST:   if (rd_ptr == wr_ptr) state_next = S_RELEASE;
            S_RELEASE: if (rel_cnt == REL_LAST) state_next = S_RUN;
            S_RUN:     if (start) state_next = S_FILL;
            default:   state_next = S_IDLE;
        endcase
    end

    // Program buffer write port.
    always_ff @(posedge clk) begin
        // NOTE: the buffer RAM has no reset; the pointers alone define which
        // entries are valid, so stale contents are never read.
        if (transfer) begin
            buffer[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    // Pointers, counters and the registered CPU-facing outputs.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            rel_cnt          <= '0;
            trunc            <= 1'b0;
            LoadInstructions <= 1'b0;
            Instruction      <= '0;
            cpu_reset        <= 1'b1;
            done             <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_RUN: begin
                    if (start) begin
                        wr_ptr    <= '0;
                        rd_ptr    <= '0;
                        trunc     <= 1'b0;
                        cpu_reset <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (transfer) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        // Buffer filled without an end marker: the program was cut short.
                        if (!in_last && wr_ptr == LAST_SLOT) begin
                            trunc <= 1'b1;
                        end
                    end
                end
                S_BURST: begin
                    if (rd_ptr != wr_ptr) begin
                        // cpu_reset drops together with the first load strobe so
                        // the CPU's address counter starts at word 0.
                        LoadInstructions <= 1'b1;
                        Instruction      <= buffer[rd_ptr[AW-1:0]];
                        cpu_reset        <= 1'b0;
                        rd_ptr           <= rd_ptr + 1'b1;
                    end else begin
                        LoadInstructions <= 1'b0;
                        Instruction      <= '0;
                        cpu_reset        <= 1'b1;
                        rel_cnt          <= '0;
                    end
                end
                S_RELEASE: begin
                    if (rel_cnt == REL_LAST) begin
                        cpu_reset <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        rel_cnt <= rel_cnt + 1'b1;
                    end
                end
                default: begin
                    cpu_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader (MAX_WORDS=32, RELEASE_CYCLES=2).
// Accepted words are pushed to a scoreboard queue; a monitor pops one entry
// per LoadInstructions cycle and compares it with Instruction.
module tb_program_loader;

    logic        clk      = 1'b0;
    logic        Reset    = 1'b0;
    logic        start    = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data  = '0;
    logic        in_last  = 1'b0;
    logic        in_ready;
    logic        LoadInstructions;
    logic [31:0] Instruction;
    logic        cpu_reset;
    logic        done;
    logic [5:0]  word_count;
    logic        trunc;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];

    localparam logic [42:0] RESET_VEC = {1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 6'd0, 1'b0};

    program_loader #(.MAX_WORDS(32), .RELEASE_CYCLES(2)) dut (
        .clk              (clk),
        .Reset            (Reset),
        .start            (start),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_last          (in_last),
        .in_ready         (in_ready),
        .LoadInstructions (LoadInstructions),
        .Instruction      (Instruction),
        .cpu_reset        (cpu_reset),
        .done             (done),
        .word_count       (word_count),
        .trunc            (trunc)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard monitor: every loaded word must match the next accepted word.
    always @(negedge clk) begin
        logic [31:0] e;
        if (Reset && LoadInstructions) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL burst_word: got %h, expected none (scoreboard empty)", Instruction);
            end else begin
                e = exp_q.pop_front();
                if (Instruction !== e) begin
                    n_fail++;
                    $display("FAIL burst_word: got %h, expected %h", Instruction, e);
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers one word after 'idle' empty cycles; returns whether it was accepted.
    task automatic send_word(input logic [31:0] d, input logic last, input int idle,
                             output bit accepted);
        int t;
        accepted = 1'b0;
        repeat (idle) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (in_ready) begin
            exp_q.push_back(d);
            accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Measures the burst length and the following cpu_reset-high window.
    task automatic observe_burst(output int blen, output int rlen, output bit cpu_ok,
                                 output bit seen);
        int t;
        blen = 0; rlen = 0; cpu_ok = 1'b1; seen = 1'b0; t = 0;
        while (!LoadInstructions && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!LoadInstructions) return;
        seen = 1'b1;
        while (LoadInstructions && blen < 300) begin
            if (cpu_reset !== 1'b0) cpu_ok = 1'b0;
            blen++;
            @(negedge clk);
        end
        while (cpu_reset === 1'b1 && rlen < 40) begin
            rlen++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [42:0] obs;
        Reset = 1'b0;
        repeat (2) @(negedge clk);
        obs = {in_ready, LoadInstructions, Instruction, cpu_reset, done, word_count, trunc};
        n_checks++;
        if (obs !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected %h", obs, RESET_VEC);
        end
        Reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready, cpu_reset, done} !== 3'b010) begin
            n_fail++;
            $display("FAIL idle_hold: got %b, expected 010", {in_ready, cpu_reset, done});
        end
    endtask

    task automatic test_basic_load();
        logic [31:0] prog [4] = '{32'h20010005, 32'h20020003, 32'h00221820, 32'hAC030000};
        bit acc, all_acc;
        int blen, rlen;
        bit cpu_ok, seen;
        pulse_start();
        n_checks++;
        if ({in_ready, cpu_reset, word_count} !== {1'b1, 1'b1, 6'd0}) begin
            n_fail++;
            $display("FAIL basic_fill_entry: got %b %b %0d, expected 1 1 0", in_ready, cpu_reset, word_count);
        end
        all_acc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_word(prog[i], (i == 3), 0, acc);
            all_acc &= acc;
        end
        n_checks++;
        if (all_acc !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_accept: got %b, expected 1", all_acc);
        end
        observe_burst(blen, rlen, cpu_ok, seen);
        n_checks++;
        if (!seen || blen != 4) begin
            n_fail++;
            $display("FAIL basic_burst_len: got %0d (seen=%0d), expected 4", blen, seen);
        end
        n_checks++;
        if (cpu_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_cpu_reset_low: got %b, expected 1", cpu_ok);
        end
        n_checks++;
        if (rlen != 2) begin
            n_fail++;
            $display("FAIL basic_release_len: got %0d, expected 2", rlen);
        end
        n_checks++;
        if ({done, word_count, trunc, Instruction} !== {1'b1, 6'd4, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL basic_final: got done=%b wc=%0d trunc=%b instr=%h, expected 1 4 0 0",
                     done, word_count, trunc, Instruction);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_scoreboard: got %0d left, expected 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({done, cpu_reset} !== 2'b10) begin
            n_fail++;
            $display("FAIL run_hold: got %b, expected 10", {done, cpu_reset});
        end
    endtask

    task automatic test_reload();
        bit acc, all_acc;
        int blen, rlen;
        bit cpu_ok, seen;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({done, cpu_reset, word_count} !== {1'b0, 1'b1, 6'd0}) begin
            n_fail++;
            $display("FAIL reload_entry: got done=%b cpu_reset=%b wc=%0d, expected 0 1 0",
                     done, cpu_reset, word_count);
        end
        all_acc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_word(32'h3000_0000 + 32'(i), (i == 2), 0, acc);
            all_acc &= acc;
        end
        observe_burst(blen, rlen, cpu_ok, seen);
        n_checks++;
        if (!all_acc || !seen || blen != 3 || !cpu_ok || rlen != 2) begin
            n_fail++;
            $display("FAIL reload_burst: got acc=%b len=%0d cpu_ok=%b rel=%0d, expected 1 3 1 2",
                     all_acc, blen, cpu_ok, rlen);
        end
        n_checks++;
        if ({done, word_count, trunc} !== {1'b1, 6'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL reload_final: got done=%b wc=%0d trunc=%b, expected 1 3 0",
                     done, word_count, trunc);
        end
    endtask

    task automatic test_valid_gaps();
        bit acc, all_acc;
        int blen, rlen;
        bit cpu_ok, seen;
        pulse_start();
        all_acc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_word(32'h4400_0000 + 32'(i * 3), (i == 3), 1, acc);
            all_acc &= acc;
        end
        observe_burst(blen, rlen, cpu_ok, seen);
        n_checks++;
        if (!all_acc || !seen || blen != 4 || !cpu_ok) begin
            n_fail++;
            $display("FAIL gaps_burst: got acc=%b len=%0d cpu_ok=%b, expected 1 4 1", all_acc, blen, cpu_ok);
        end
        n_checks++;
        if ({done, word_count, exp_q.size() == 0} !== {1'b1, 6'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL gaps_final: got done=%b wc=%0d left=%0d, expected 1 4 0",
                     done, word_count, exp_q.size());
        end
    endtask

    task automatic test_truncate();
        bit acc, all_acc;
        int blen, rlen;
        bit cpu_ok, seen;
        pulse_start();
        all_acc = 1'b1;
        for (int i = 0; i < 32; i++) begin
            send_word(32'hA000_0000 + 32'(i), 1'b0, 0, acc);
            all_acc &= acc;
        end
        // Offer a 33rd word; it must stay pending and never be acknowledged.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        in_last  = 1'b0;
        n_checks++;
        if ({all_acc, in_ready, trunc, word_count} !== {1'b1, 1'b0, 1'b1, 6'd32}) begin
            n_fail++;
            $display("FAIL trunc_fill: got acc=%b ready=%b trunc=%b wc=%0d, expected 1 0 1 32",
                     all_acc, in_ready, trunc, word_count);
        end
        observe_burst(blen, rlen, cpu_ok, seen);
        n_checks++;
        if (!seen || blen != 32 || !cpu_ok || rlen != 2) begin
            n_fail++;
            $display("FAIL trunc_burst: got len=%0d cpu_ok=%b rel=%0d, expected 32 1 2", blen, cpu_ok, rlen);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if ({in_ready, done, word_count, trunc} !== {1'b0, 1'b1, 6'd32, 1'b1}) begin
            n_fail++;
            $display("FAIL trunc_pending: got ready=%b done=%b wc=%0d trunc=%b, expected 0 1 32 1",
                     in_ready, done, word_count, trunc);
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic test_single_word();
        bit acc;
        int blen, rlen;
        bit cpu_ok, seen;
        pulse_start();
        send_word(32'h5A5A_0001, 1'b1, 0, acc);
        observe_burst(blen, rlen, cpu_ok, seen);
        n_checks++;
        if (!acc || !seen || blen != 1 || !cpu_ok || rlen != 2) begin
            n_fail++;
            $display("FAIL single_burst: got acc=%b len=%0d cpu_ok=%b rel=%0d, expected 1 1 1 2",
                     acc, blen, cpu_ok, rlen);
        end
        n_checks++;
        if ({done, word_count, trunc} !== {1'b1, 6'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_final: got done=%b wc=%0d trunc=%b, expected 1 1 0",
                     done, word_count, trunc);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit acc, all_acc;
        int t, blen, rlen;
        bit cpu_ok, seen;
        logic [42:0] obs;
        pulse_start();
        send_word(32'h1111_0000, 1'b0, 0, acc);
        send_word(32'h1111_0001, 1'b1, 0, acc);
        t = 0;
        while (!LoadInstructions && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (LoadInstructions !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_burst_start: got %b, expected 1", LoadInstructions);
        end
        // Assert reset just after the edge that starts the second burst cycle.
        @(posedge clk);
        #2;
        Reset = 1'b0;
        #1;
        obs = {in_ready, LoadInstructions, Instruction, cpu_reset, done, word_count, trunc};
        n_checks++;
        if (obs !== RESET_VEC) begin
            n_fail++;
            $display("FAIL abort_reset_outputs: got %h, expected %h", obs, RESET_VEC);
        end
        exp_q.delete();
        @(negedge clk);
        Reset = 1'b1;
        pulse_start();
        all_acc = 1'b1;
        send_word(32'h2222_0000, 1'b0, 0, acc);
        all_acc &= acc;
        send_word(32'h2222_0001, 1'b1, 0, acc);
        all_acc &= acc;
        observe_burst(blen, rlen, cpu_ok, seen);
        n_checks++;
        if (!all_acc || !seen || blen != 2 || !cpu_ok) begin
            n_fail++;
            $display("FAIL abort_reload_burst: got acc=%b len=%0d cpu_ok=%b, expected 1 2 1", all_acc, blen, cpu_ok);
        end
        n_checks++;
        if ({done, word_count, exp_q.size() == 0} !== {1'b1, 6'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL abort_reload_final: got done=%b wc=%0d left=%0d, expected 1 2 0",
                     done, word_count, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_reload();
        test_valid_gaps();
        test_truncate();
        test_single_word();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
